timer_apb_arbiter: RTL and testbench

//  Two-requester APB master that shares the single APB slave port of the 8-bit timer.

---
 rtl/timer_apb_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_timer_apb_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_apb_arbiter.sv
// Round-robin two-requester APB master in front of the timer's single APB slave port.
// Define ARB_TIMEOUT_EN to abort ACCESS phases that see no pready within TIMEOUT cycles.
module timer_apb_arbiter #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned TO_W    = 5
) (
   input  logic       cpu_clk,
   input  logic       cpu_reset,
   input  logic       r0_req,
   input  logic       r0_write,
   input  logic [7:0] r0_addr,
   input  logic [7:0] r0_wdata,
   output logic       r0_done,
   output logic [7:0] r0_rdata,
   output logic       r0_err,
   input  logic       r1_req,
   input  logic       r1_write,
   input  logic [7:0] r1_addr,
   input  logic [7:0] r1_wdata,
   output logic       r1_done,
   output logic [7:0] r1_rdata,
   output logic       r1_err,
   output logic       cpu_psel,
   output logic       cpu_penable,
   output logic       cpu_pwrite,
   output logic [7:0] cpu_paddr,
   output logic [7:0] cpu_pwdata,
   input  logic [7:0] cpu_prdata,
   input  logic       cpu_pready,
   input  logic       cpu_pslverr
);

   if ((64'd1 << TO_W) <= 64'(TIMEOUT)) begin : g_bad_to_w
      $error("TO_W is too narrow to hold TIMEOUT");
   end

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

   state_e     state_q, state_d;
   logic       rr_q, rr_d;     // 0: r0 wins a tie, 1: r1 wins a tie
   logic       gnt_q, gnt_d;   // requester owning the current transfer
   logic       psel_q, psel_d;
   logic       penable_q, penable_d;
   logic       pwrite_q, pwrite_d;
   logic [7:0] paddr_q, paddr_d;
   logic [7:0] pwdata_q, pwdata_d;
   logic       r0_done_q, r0_done_d;
   logic [7:0] r0_rdata_q, r0_rdata_d;
   logic       r0_err_q, r0_err_d;
   logic       r1_done_q, r1_done_d;
   logic [7:0] r1_rdata_q, r1_rdata_d;
   logic       r1_err_q, r1_err_d;

   logic       win;
   logic       fin;
   logic       fin_err;
   logic [7:0] fin_rdata;

`ifdef ARB_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

   assign win = (r0_req && r1_req) ? rr_q : r1_req;

   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      gnt_d      = gnt_q;
      psel_d     = psel_q;
      penable_d  = penable_q;
      pwrite_d   = pwrite_q;
      paddr_d    = paddr_q;
      pwdata_d   = pwdata_q;
      r0_done_d  = 1'b0;
      r0_rdata_d = 8'h00;
      r0_err_d   = 1'b0;
      r1_done_d  = 1'b0;
      r1_rdata_d = 8'h00;
      r1_err_d   = 1'b0;
      fin        = 1'b0;
      fin_err    = 1'b0;
      fin_rdata  = 8'h00;
`ifdef ARB_TIMEOUT_EN
      to_cnt_d   = to_cnt_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (r0_req || r1_req) begin
               gnt_d    = win;
               rr_d     = ~win;
               psel_d   = 1'b1;
               pwrite_d = win ? r1_write : r0_write;
               paddr_d  = win ? r1_addr  : r0_addr;
               pwdata_d = win ? r1_wdata : r0_wdata;
               state_d  = StSetup;
            end
         end
         StSetup: begin
            penable_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
            to_cnt_d  = '0;
`endif
            state_d   = StAccess;
         end
         StAccess: begin
            if (cpu_pready) begin
               fin       = 1'b1;
               fin_err   = cpu_pslverr;
               fin_rdata = pwrite_q ? 8'h00 : cpu_prdata;
            end
`ifdef ARB_TIMEOUT_EN
            // This cycle is the TIMEOUT-th one without pready: abort with an error.
            else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
               fin       = 1'b1;
               fin_err   = 1'b1;
               fin_rdata = 8'h00;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
`endif
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (fin) begin
         state_d   = StDone;
         psel_d    = 1'b0;
         penable_d = 1'b0;
         pwrite_d  = 1'b0;
         paddr_d   = 8'h00;
         pwdata_d  = 8'h00;
         if (gnt_q) begin
            r1_done_d  = 1'b1;
            r1_rdata_d = fin_rdata;
            r1_err_d   = fin_err;
         end else begin
            r0_done_d  = 1'b1;
            r0_rdata_d = fin_rdata;
            r0_err_d   = fin_err;
         end
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (cpu_reset) begin
         state_q    <= StIdle;
         rr_q       <= 1'b0;
         gnt_q      <= 1'b0;
         psel_q     <= 1'b0;
         penable_q  <= 1'b0;
         pwrite_q   <= 1'b0;
         paddr_q    <= 8'h00;
         pwdata_q   <= 8'h00;
         r0_done_q  <= 1'b0;
         r0_rdata_q <= 8'h00;
         r0_err_q   <= 1'b0;
         r1_done_q  <= 1'b0;
         r1_rdata_q <= 8'h00;
         r1_err_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         to_cnt_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         gnt_q      <= gnt_d;
         psel_q     <= psel_d;
         penable_q  <= penable_d;
         pwrite_q   <= pwrite_d;
         paddr_q    <= paddr_d;
         pwdata_q   <= pwdata_d;
         r0_done_q  <= r0_done_d;
         r0_rdata_q <= r0_rdata_d;
         r0_err_q   <= r0_err_d;
         r1_done_q  <= r1_done_d;
         r1_rdata_q <= r1_rdata_d;
         r1_err_q   <= r1_err_d;
`ifdef ARB_TIMEOUT_EN
         to_cnt_q   <= to_cnt_d;
`endif
      end
   end

   assign cpu_psel    = psel_q;
   assign cpu_penable = penable_q;
   assign cpu_pwrite  = pwrite_q;
   assign cpu_paddr   = paddr_q;
   assign cpu_pwdata  = pwdata_q;
   assign r0_done     = r0_done_q;
   assign r0_rdata    = r0_rdata_q;
   assign r0_err      = r0_err_q;
   assign r1_done     = r1_done_q;
   assign r1_rdata    = r1_rdata_q;
   assign r1_err      = r1_err_q;

endmodule

// File: tb/tb_timer_apb_arbiter.sv
// Self-checking bench for timer_apb_arbiter: directed vector table, corner sequences
// and a randomized run checked against a transaction-level arbitration model.
module tb_timer_apb_arbiter;

   localparam int unsigned TO = 8;

   logic       cpu_clk = 1'b0;
   logic       cpu_reset;
   logic       r0_req, r0_write, r0_done, r0_err;
   logic [7:0] r0_addr, r0_wdata, r0_rdata;
   logic       r1_req, r1_write, r1_done, r1_err;
   logic [7:0] r1_addr, r1_wdata, r1_rdata;
   logic       cpu_psel, cpu_penable, cpu_pwrite, cpu_pready, cpu_pslverr;
   logic [7:0] cpu_paddr, cpu_pwdata, cpu_prdata;

   int n_chk = 0;
   int n_fail = 0;

   timer_apb_arbiter #(
      .TIMEOUT (TO),
      .TO_W    (5)
   ) dut (
      .cpu_clk     (cpu_clk),
      .cpu_reset   (cpu_reset),
      .r0_req      (r0_req),
      .r0_write    (r0_write),
      .r0_addr     (r0_addr),
      .r0_wdata    (r0_wdata),
      .r0_done     (r0_done),
      .r0_rdata    (r0_rdata),
      .r0_err      (r0_err),
      .r1_req      (r1_req),
      .r1_write    (r1_write),
      .r1_addr     (r1_addr),
      .r1_wdata    (r1_wdata),
      .r1_done     (r1_done),
      .r1_rdata    (r1_rdata),
      .r1_err      (r1_err),
      .cpu_psel    (cpu_psel),
      .cpu_penable (cpu_penable),
      .cpu_pwrite  (cpu_pwrite),
      .cpu_paddr   (cpu_paddr),
      .cpu_pwdata  (cpu_pwdata),
      .cpu_prdata  (cpu_prdata),
      .cpu_pready  (cpu_pready),
      .cpu_pslverr (cpu_pslverr)
   );

   always #5 cpu_clk = ~cpu_clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int         rq;
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      int         waits;
      logic [7:0] prdata;
      logic       slverr;
      logic [7:0] exp_rdata;
      logic       exp_err;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   function automatic logic [18:0] bus();
      return {cpu_psel, cpu_penable, cpu_pwrite, cpu_paddr, cpu_pwdata};
   endfunction

   function automatic logic [38:0] outs();
      return {r0_done, r0_rdata, r0_err, r1_done, r1_rdata, r1_err, bus()};
   endfunction

   task automatic set_req(input int rq, input logic req, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wdata);
      if (rq == 0) begin
         r0_req = req; r0_write = wr; r0_addr = addr; r0_wdata = wdata;
      end else begin
         r1_req = req; r1_write = wr; r1_addr = addr; r1_wdata = wdata;
      end
   endtask

   task automatic do_reset();
      cpu_reset = 1'b1;
      set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
      set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
      cpu_pready = 1'b0; cpu_pslverr = 1'b0; cpu_prdata = 8'h00;
      @(negedge cpu_clk);
      @(negedge cpu_clk);
      cpu_reset = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic [19:0] er;
      set_req(v.rq, 1'b1, v.wr, v.addr, v.wdata);
      cpu_pready = 1'b0;
      @(negedge cpu_clk);
      check($sformatf("v%0d setup bus", idx), bus(), {1'b1, 1'b0, v.wr, v.addr, v.wdata});
      for (int i = 0; i <= v.waits; i++) begin
         @(negedge cpu_clk);
         check($sformatf("v%0d access%0d bus", idx, i), bus(),
               {1'b1, 1'b1, v.wr, v.addr, v.wdata});
         check($sformatf("v%0d access%0d no done", idx, i), {r0_done, r1_done}, 2'b00);
         cpu_pready  = (i == v.waits);
         cpu_pslverr = (i == v.waits) ? v.slverr : ~v.slverr;
         cpu_prdata  = (i == v.waits) ? v.prdata : 8'hEE;
      end
      @(negedge cpu_clk);
      er = (v.rq == 0) ? {1'b1, v.exp_rdata, v.exp_err, 10'b0}
                       : {10'b0, 1'b1, v.exp_rdata, v.exp_err};
      check($sformatf("v%0d done outputs", idx), outs(), {er, 19'b0});
      set_req(v.rq, 1'b0, 1'b0, 8'h00, 8'h00);
      cpu_pready = 1'b0; cpu_pslverr = 1'b0; cpu_prdata = 8'h00;
      @(negedge cpu_clk);
      check($sformatf("v%0d after done outputs", idx), outs(), 39'b0);
   endtask

   task automatic both_continuous();
      int n, ns, c0, c1;
      do_reset();
      set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
      set_req(1, 1'b1, 1'b0, 8'h20, 8'h00);
      cpu_pready = 1'b1; cpu_prdata = 8'h5C; cpu_pslverr = 1'b0;
      n = 0; ns = 0; c0 = 0; c1 = 0;
      for (int c = 0; c < 100 && n < 8; c++) begin
         @(negedge cpu_clk);
         if (cpu_psel && !cpu_penable) begin
            check($sformatf("rr grant %0d addr", ns), cpu_paddr,
                  (ns % 2 == 0) ? 8'h10 + 8'(ns / 2) : 8'h20 + 8'(ns / 2));
            ns++;
         end
         if (r0_done || r1_done) begin
            check($sformatf("rr done %0d order", n), {r0_done, r1_done},
                  (n % 2 == 0) ? 2'b10 : 2'b01);
            n++;
            if (r0_done) begin
               c0++;
               if (c0 == 4) r0_req = 1'b0;
               else r0_addr = r0_addr + 8'h01;
            end else begin
               c1++;
               if (c1 == 4) r1_req = 1'b0;
               else r1_addr = r1_addr + 8'h01;
            end
         end
      end
      check("rr transfer count", n, 8);
   endtask

   task automatic reset_mid(input int who);
      logic [7:0] r0a;
      do_reset();
      set_req(who, 1'b1, 1'b0, 8'h30, 8'h00);
      r0a = (who == 0) ? 8'h30 : 8'h40;
      @(negedge cpu_clk);
      @(negedge cpu_clk);
      check($sformatf("rst_mid%0d in access", who), {cpu_psel, cpu_penable}, 2'b11);
      cpu_reset = 1'b1;
      @(negedge cpu_clk);
      check($sformatf("rst_mid%0d outputs cleared", who), outs(), 39'b0);
      cpu_reset = 1'b0;
      set_req(1 - who, 1'b1, 1'b0, 8'h40, 8'h00);
      @(negedge cpu_clk);
      check($sformatf("rst_mid%0d r0 granted first", who), bus(),
            {1'b1, 1'b0, 1'b0, r0a, 8'h00});
      @(negedge cpu_clk);
      check($sformatf("rst_mid%0d no done", who), {r0_done, r1_done}, 2'b00);
      do_reset();
   endtask

   task automatic stuck_ready();
      int acc;
      logic got;
      do_reset();
      set_req(0, 1'b1, 1'b0, 8'h07, 8'h00);
      cpu_pready = 1'b0; cpu_prdata = 8'hAB; cpu_pslverr = 1'b1;
      acc = 0; got = 1'b0;
`ifdef ARB_TIMEOUT_EN
      for (int c = 0; c < 100 && !got; c++) begin
         @(negedge cpu_clk);
         if (r0_done) begin
            check("timeout access cycles", acc, TO);
            check("timeout resp", {r0_rdata, r0_err}, {8'h00, 1'b1});
            r0_req = 1'b0;
            got = 1'b1;
         end else if (cpu_psel && cpu_penable) begin
            acc++;
         end
      end
      check("timeout done seen", got, 1'b1);
`else
      @(negedge cpu_clk);
      for (int c = 0; c < 100; c++) begin
         @(negedge cpu_clk);
         if (cpu_psel && cpu_penable && !r0_done && !r1_done) acc++;
      end
      check("no timeout: access held", acc, 100);
`endif
      do_reset();
   endtask

   task automatic random_phase();
      int         last_g, cur, win, n_done, quiet;
      logic       exp_done, exp_err, d0, d1;
      logic [7:0] exp_rdata;
      logic [1:0] rq_v, rw;
      logic [7:0] ra [2];
      logic [7:0] rd [2];
      do_reset();
      last_g = 1; cur = 0; n_done = 0; quiet = 0;
      exp_done = 1'b0; exp_err = 1'b0; exp_rdata = 8'h00;
      rq_v = 2'b00; rw = 2'b00;
      for (int i = 0; i < 2; i++) begin
         ra[i] = 8'h00; rd[i] = 8'h00;
      end
      for (int c = 0; c < 3000; c++) begin
         @(negedge cpu_clk);
         d0 = exp_done && (cur == 0);
         d1 = exp_done && (cur == 1);
         check("rnd r0 resp", {r0_done, r0_rdata, r0_err}, d0 ? {1'b1, exp_rdata, exp_err} : 10'd0);
         check("rnd r1 resp", {r1_done, r1_rdata, r1_err}, d1 ? {1'b1, exp_rdata, exp_err} : 10'd0);
         if (cpu_psel && !cpu_penable) begin
            check("rnd setup with req", (rq_v != 2'b00), 1'b1);
            win = (rq_v[0] && rq_v[1]) ? ((last_g == 0) ? 1 : 0) : (rq_v[1] ? 1 : 0);
            check("rnd setup bus", bus(), {1'b1, 1'b0, rw[win], ra[win], rd[win]});
            cur = win;
            last_g = win;
         end else if (cpu_psel && cpu_penable) begin
            check("rnd access bus", bus(), {1'b1, 1'b1, rw[cur], ra[cur], rd[cur]});
         end else begin
            check("rnd idle bus", bus(), 19'b0);
         end
         if (exp_done) begin
            n_done++;
            quiet = 0;
            if ($urandom_range(0, 1) == 1) begin
               rw[cur] = 1'($urandom); ra[cur] = 8'($urandom); rd[cur] = 8'($urandom);
            end else begin
               rq_v[cur] = 1'b0;
            end
         end
         exp_done = 1'b0;
         cpu_prdata  = 8'($urandom);
         cpu_pslverr = 1'($urandom);
         if (cpu_psel && cpu_penable) begin
            cpu_pready = ($urandom_range(0, 2) != 0);
            if (cpu_pready) begin
               exp_done  = 1'b1;
               exp_rdata = rw[cur] ? 8'h00 : cpu_prdata;
               exp_err   = cpu_pslverr;
            end
         end else begin
            cpu_pready = 1'($urandom);
         end
         for (int i = 0; i < 2; i++) begin
            if (!rq_v[i] && $urandom_range(0, 2) == 0) begin
               rq_v[i] = 1'b1;
               rw[i] = 1'($urandom); ra[i] = 8'($urandom); rd[i] = 8'($urandom);
            end
         end
         set_req(0, rq_v[0], rw[0], ra[0], rd[0]);
         set_req(1, rq_v[1], rw[1], ra[1], rd[1]);
         if (rq_v == 2'b00) quiet = 0;
         else quiet++;
         if (quiet > 60) begin
            check("rnd progress stall cycles", quiet, 0);
            break;
         end
      end
      check("rnd enough transfers", (n_done > 150), 1'b1);
      do_reset();
   endtask

   initial begin
      vecs[0] = '{0, 1'b1, 8'h02, 8'h5A, 0, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[1] = '{1, 1'b0, 8'h01, 8'h00, 3, 8'hC3, 1'b0, 8'hC3, 1'b0};
      vecs[2] = '{0, 1'b0, 8'h09, 8'h00, 0, 8'h77, 1'b1, 8'h77, 1'b1};
      vecs[3] = '{0, 1'b0, 8'h09, 8'h00, 0, 8'h42, 1'b0, 8'h42, 1'b0};
      vecs[4] = '{1, 1'b1, 8'h0F, 8'hA5, 1, 8'h99, 1'b1, 8'h00, 1'b1};
      vecs[5] = '{0, 1'b1, 8'hFF, 8'hFF, 2, 8'h3C, 1'b0, 8'h00, 1'b0};
      vecs[6] = '{1, 1'b0, 8'h00, 8'h11, 0, 8'hFF, 1'b0, 8'hFF, 1'b0};

      do_reset();
      check("reset outputs", outs(), 39'b0);

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      both_continuous();
      reset_mid(1);
      reset_mid(0);
      stuck_ready();
      random_phase();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
